// File: rtl/xmul_arb_pkg.sv
// xmul_arb_pkg: shared types and constants for the shared-multiplier arbiter
// and its round-robin picker.
package xmul_arb_pkg;

   localparam int DATA_W_DEF  = 32;
   localparam int MUL_LAT_DEF = 4;

   localparam logic [1:0] RUN_ENC   = 2'd0;
   localparam logic [1:0] DRAIN_ENC = 2'd1;
   localparam logic [1:0] DONE_ENC  = 2'd2;

   typedef enum logic [1:0] {
      ST_RUN   = RUN_ENC,
      ST_DRAIN = DRAIN_ENC,
      ST_DONE  = DONE_ENC
   } arb_state_t;

   // Ceiling log2, usable in constant expressions (clog2(1) = 0).
   function automatic int clog2(input int v);
      int r;
      int x;
      r = 0;
      x = v - 1;
      while (x > 0) begin
         r++;
         x = x >> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/xmul_rr_pick.sv
// xmul_rr_pick: combinational round-robin picker. Searches from ptr+1
// (mod N) upward and returns the first requester found, as a one-hot grant
// and as an index. Reusable for any shared single-issue functional unit.
module xmul_rr_pick #(
   parameter int N  = 4,
   parameter int IW = 2
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  gnt,
   output logic [IW-1:0] idx,
   output logic          hit
);

   int k;

   // Rotating first-one search starting just past the last winner
   always_comb begin
      gnt = '0;
      idx = '0;
      hit = 1'b0;
      k   = 0;
      for (int i = 1; i <= N; i++) begin
         k = (int'(ptr) + i) % N;
         if (!hit && req[k]) begin
            hit    = 1'b1;
            gnt[k] = 1'b1;
            idx    = IW'(k);
         end
      end
   end

endmodule

// File: rtl/xmul_arbiter.sv
// xmul_arbiter: shares one fixed-latency, non-stalling signed multiplier
// between N_REQ requesters. Round-robin issue of one operand pair per cycle,
// a tag pipeline that returns each product with its owner's ID, and a flush
// FSM that stops issue and reports when the multiplier is empty.
// Optional build macro XMUL_ARB_STATS_EN adds issue/stall counters.
module xmul_arbiter
   import xmul_arb_pkg::*;
#(
   parameter int DATA_W  = DATA_W_DEF,
   parameter int N_REQ   = 4,
   parameter int ID_W    = 2,
   parameter int MUL_LAT = MUL_LAT_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [N_REQ-1:0]        req_valid,
   output logic [N_REQ-1:0]        req_ready,
   input  logic [N_REQ*DATA_W-1:0] req_op_a,
   input  logic [N_REQ*DATA_W-1:0] req_op_b,
   output logic [DATA_W-1:0]       mul_op_a,
   output logic [DATA_W-1:0]       mul_op_b,
   input  logic [2*DATA_W-1:0]     mul_product,
   output logic                    res_valid,
   output logic [ID_W-1:0]         res_id,
   output logic [2*DATA_W-1:0]     res_product,
   input  logic                    flush_req,
   output logic                    flush_done
`ifdef XMUL_ARB_STATS_EN
   ,
   output logic [31:0]             stat_issue,
   output logic [31:0]             stat_stall
`endif
);

   localparam int CNT_W = clog2(MUL_LAT + 2);

   arb_state_t                 state;
   logic [ID_W-1:0]            rr_ptr;
   logic                       arb_en;
   logic [N_REQ-1:0]           pick_req;
   logic [N_REQ-1:0]           gnt;
   logic [ID_W-1:0]            gnt_idx;
   logic                       issue;
   logic [DATA_W-1:0]          sel_a;
   logic [DATA_W-1:0]          sel_b;
   // Stages 0..MUL_LAT-1 track the multiplier; stage MUL_LAT is the
   // registered result tag that drives res_valid/res_id.
   logic [MUL_LAT:0]           vld_pipe;
   logic [MUL_LAT:0][ID_W-1:0] id_pipe;
   logic [CNT_W-1:0]           inflight_cnt;
   logic                       retire;
   logic                       pipe_busy;

   // Issue only in RUN with no flush pending; a flush request blocks issue
   // in the very cycle it is raised. Held off while reset is asserted.
   assign arb_en   = rst && (state == ST_RUN) && !flush_req;
   assign pick_req = arb_en ? req_valid : '0;

   xmul_rr_pick #(
      .N  (N_REQ),
      .IW (ID_W)
   ) u_pick (
      .req (pick_req),
      .ptr (rr_ptr),
      .gnt (gnt),
      .idx (gnt_idx),
      .hit (issue)
   );

   // Ready is the grant itself, so valid & ready is exactly the grant.
   assign req_ready = gnt;
   assign sel_a     = req_op_a[int'(gnt_idx)*DATA_W +: DATA_W];
   assign sel_b     = req_op_b[int'(gnt_idx)*DATA_W +: DATA_W];

   // A tag retires as it moves into the result register, so the count
   // covers exactly the products still inside the multiplier.
   assign retire    = vld_pipe[MUL_LAT-1];
   assign pipe_busy = |vld_pipe[MUL_LAT-1:0];

   assign res_valid   = vld_pipe[MUL_LAT];
   assign res_id      = id_pipe[MUL_LAT];
   assign res_product = mul_product;

   // Operand registers: granted pair on issue, zeros on idle cycles
   always_ff @(posedge clk) begin
      if (!rst) begin
         mul_op_a <= '0;
         mul_op_b <= '0;
      end else if (issue) begin
         mul_op_a <= sel_a;
         mul_op_b <= sel_b;
      end else begin
         mul_op_a <= '0;
         mul_op_b <= '0;
      end
   end

   // Round-robin pointer remembers the last winner
   always_ff @(posedge clk) begin
      if (!rst)
         rr_ptr <= ID_W'(N_REQ - 1);
      else if (issue)
         rr_ptr <= gnt_idx;
   end

   // Tag pipeline mirrors the multiplier; reset discards every tag so stale
   // products never surface as results.
   always_ff @(posedge clk) begin
      if (!rst) begin
         vld_pipe <= '0;
         id_pipe  <= '0;
      end else begin
         vld_pipe <= {vld_pipe[MUL_LAT-1:0], issue};
         id_pipe  <= {id_pipe[MUL_LAT-1:0], gnt_idx & {ID_W{issue}}};
      end
   end

   // In-flight count: up on issue, down on retire, hold when both
   always_ff @(posedge clk) begin
      if (!rst)
         inflight_cnt <= '0;
      else if (issue && !retire)
         inflight_cnt <= inflight_cnt + CNT_W'(1);
      else if (!issue && retire)
         inflight_cnt <= inflight_cnt - CNT_W'(1);
   end

   // Flush FSM: RUN -> DRAIN on request, DRAIN -> DONE once the multiplier
   // is empty, DONE -> RUN when the request is withdrawn.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= ST_RUN;
         flush_done <= 1'b0;
      end else begin
         case (state)
            ST_RUN: begin
               if (flush_req)
                  state <= ST_DRAIN;
            end
            ST_DRAIN: begin
               if (inflight_cnt == '0 && !pipe_busy) begin
                  state      <= ST_DONE;
                  flush_done <= 1'b1;
               end
            end
            ST_DONE: begin
               if (!flush_req) begin
                  state      <= ST_RUN;
                  flush_done <= 1'b0;
               end
            end
            default: begin
               state      <= ST_RUN;
               flush_done <= 1'b0;
            end
         endcase
      end
   end

`ifdef XMUL_ARB_STATS_EN
   // Issue and contention counters, free-running and wrapping
   always_ff @(posedge clk) begin
      if (!rst) begin
         stat_issue <= '0;
         stat_stall <= '0;
      end else begin
         if (issue)
            stat_issue <= stat_issue + 32'd1;
         if (|req_valid && !issue)
            stat_stall <= stat_stall + 32'd1;
      end
   end
`endif

endmodule
